axi_chan_stream_arb: RTL and testbench

Round-robin, packet-locked arbiter that merges the five per-channel capture streams (AR, AW, R, W, B) into the single AXI4-Stream output of the AXI-to-stream monitor. Each granted packet is forwarded whole, tagged with its source channel ID, and terminated cleanly if its channel is disabled mid-packet. It sits between the per-channel capture units and the outbound stream port.

---
 rtl/axi_chan_stream_pkg.sv | 22 ++
 rtl/axi_chan_stream_arb_rr.sv | 32 +++
 rtl/axi_chan_stream_arb.sv | 130 +++++++++++++
 tb/tb_axi_chan_stream_arb.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_chan_stream_pkg.sv
// Shared types and constants for the AXI channel stream arbiter: FSM state
// encoding, fixed channel indices and default widths.
package axi_chan_stream_pkg;

  localparam int DEFAULT_N_CH   = 5;
  localparam int DEFAULT_DATA_W = 64;
  localparam int DEFAULT_ID_W   = 3;

  // Channel indices double as the channel ID carried in m_tuser.
  localparam int CH_AR = 0;
  localparam int CH_AW = 1;
  localparam int CH_R  = 2;
  localparam int CH_W  = 3;
  localparam int CH_B  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/axi_chan_stream_arb_rr.sv
// Combinational rotate-priority select: picks the first requester strictly
// after last_grant, wrapping modulo N_CH.
module rr_arbiter
  import axi_chan_stream_pkg::*;
#(
  parameter int N_CH = DEFAULT_N_CH,
  parameter int ID_W = DEFAULT_ID_W
) (
  input  logic [N_CH-1:0] req,
  input  logic [ID_W-1:0] last_grant,
  output logic [ID_W-1:0] gnt_idx,
  output logic            gnt_valid
);

  always_comb begin
    int cand;
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = 0;
    // Offset 1..N_CH visits last_grant itself last, so it has lowest priority.
    for (int k = 1; k <= N_CH; k++) begin
      cand = (int'(last_grant) + k) % N_CH;
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/axi_chan_stream_arb.sv
// Packet-locked round-robin merge of the per-channel capture streams into one
// AXI4-Stream, tagging each beat with {abort, channel_id}.
module axi_chan_stream_arb
  import axi_chan_stream_pkg::*;
#(
  parameter int N_CH   = DEFAULT_N_CH,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ID_W   = DEFAULT_ID_W   // 2**ID_W must cover N_CH
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [N_CH-1:0]        ch_en,
  input  logic [N_CH-1:0]        s_tvalid,
  output logic [N_CH-1:0]        s_tready,
  input  logic [N_CH*DATA_W-1:0] s_tdata,
  input  logic [N_CH-1:0]        s_tlast,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [DATA_W-1:0]      m_tdata,
  output logic                   m_tlast,
  output logic [ID_W:0]          m_tuser,
  output logic                   busy
);

  localparam logic [ID_W-1:0] FIRST_CH = ID_W'(CH_AR);
  localparam logic [ID_W-1:0] LAST_CH  = ID_W'(N_CH - 1);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   last_grant;
  logic [N_CH-1:0]   req;
  logic [ID_W-1:0]   arb_idx;
  logic              arb_valid;
  logic              out_free;
  logic              grant_en;
  logic              grant_valid;
  logic              grant_last;
  logic [DATA_W-1:0] grant_data;
  logic              load_beat;
  logic              load_abort;

  assign req         = s_tvalid & ch_en;
  assign out_free    = !m_tvalid || m_tready;
  assign grant_en    = ch_en[grant];
  assign grant_valid = s_tvalid[grant];
  assign grant_last  = s_tlast[grant];
  assign grant_data  = s_tdata[int'(grant)*DATA_W +: DATA_W];

  rr_arbiter #(
    .N_CH (N_CH),
    .ID_W (ID_W)
  ) u_rr (
    .req        (req),
    .last_grant (last_grant),
    .gnt_idx    (arb_idx),
    .gnt_valid  (arb_valid)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (arb_valid) state_nxt = ST_XFER;
      // A tlast handshake wins over a disable seen in the same cycle.
      ST_XFER: begin
        if (load_beat && grant_last) state_nxt = ST_IDLE;
        else if (!grant_en)          state_nxt = ST_ABORT;
      end
      ST_ABORT: if (out_free) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_tready   = '0;
    load_beat  = 1'b0;
    load_abort = 1'b0;
    unique case (state)
      ST_XFER: begin
        s_tready[grant] = grant_en && out_free;
        load_beat       = grant_en && out_free && grant_valid;
      end
      ST_ABORT: load_abort = out_free;
      default: ;
    endcase
  end

  // Grant is latched in IDLE and held for the whole packet.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      grant      <= FIRST_CH;
      last_grant <= LAST_CH;
    end else begin
      if (state == ST_IDLE && arb_valid)           grant      <= arb_idx;
      if ((load_beat && grant_last) || load_abort) last_grant <= grant;
    end
  end

  // Single output register: the only path from s_* to m_* goes through it.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
      m_tuser  <= '0;
    end else if (load_beat) begin
      m_tvalid <= 1'b1;
      m_tdata  <= grant_data;
      m_tlast  <= grant_last;
      m_tuser  <= {1'b0, grant};
    end else if (load_abort) begin
      m_tvalid <= 1'b1;
      m_tdata  <= '0;
      m_tlast  <= 1'b1;
      m_tuser  <= {1'b1, grant};
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

  assign busy = (state != ST_IDLE) || m_tvalid;

endmodule

// File: tb/tb_axi_chan_stream_arb.sv
// Self-checking bench for axi_chan_stream_arb: queue-based sources, a beat
// scoreboard derived from accepted inputs and channel disables, directed cases.
module tb_axi_chan_stream_arb;

  localparam int N_CH   = 5;
  localparam int DATA_W = 64;
  localparam int ID_W   = 3;

  typedef struct {
    logic              abort;
    int                id;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  logic                   aclk;
  logic                   areset;
  logic [N_CH-1:0]        ch_en;
  logic [N_CH-1:0]        s_tvalid;
  logic [N_CH-1:0]        s_tready;
  logic [N_CH*DATA_W-1:0] s_tdata;
  logic [N_CH-1:0]        s_tlast;
  logic                   m_tvalid;
  logic                   m_tready;
  logic [DATA_W-1:0]      m_tdata;
  logic                   m_tlast;
  logic [ID_W:0]          m_tuser;
  logic                   busy;

  axi_chan_stream_arb #(
    .N_CH   (N_CH),
    .DATA_W (DATA_W),
    .ID_W   (ID_W)
  ) dut (
    .aclk     (aclk),
    .areset   (areset),
    .ch_en    (ch_en),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .s_tlast  (s_tlast),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tlast  (m_tlast),
    .m_tuser  (m_tuser),
    .busy     (busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic [DATA_W:0] src_q [N_CH][$];  // {last, data} per pending source beat
  beat_t           exp_q[$];
  int              pkt_id_q[$];
  int              pkt_cyc_q[$];
  int              out_beats[8];
  int              abort_cnt;
  int              open_ch;
  int              last_hs_ch;
  bit              out_in_pkt;
  int              cyc;
  int              rdy_mode;
  int              n_cmp;
  int              n_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic add_pkt(input int c, input int len);
    for (int i = 0; i < len; i++)
      src_q[c].push_back({(i == len - 1) ? 1'b1 : 1'b0, $urandom(), $urandom()});
  endtask

  task automatic clear_stats();
    pkt_id_q.delete();
    pkt_cyc_q.delete();
    for (int i = 0; i < 8; i++) out_beats[i] = 0;
    abort_cnt = 0;
  endtask

  // Observe one cycle just before its active edge and update the model.
  task automatic sample();
    logic [DATA_W:0] b;
    int id;
    check("s_tready_onehot", 64'($countones(s_tready) <= 1), 1);
    for (int c = 0; c < N_CH; c++)
      if (!ch_en[c]) check("s_tready_disabled", s_tready[c], 0);
    if (m_tvalid) begin
      check("beat_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        check("m_tdata", m_tdata, exp_q[0].data);
        check("m_tlast", m_tlast, exp_q[0].last);
        check("m_tuser", m_tuser, {exp_q[0].abort, ID_W'(exp_q[0].id)});
        if (m_tready) begin
          id = int'(m_tuser[ID_W-1:0]);
          out_beats[id]++;
          if (m_tuser[ID_W]) abort_cnt++;
          if (!out_in_pkt) begin
            pkt_id_q.push_back(id);
            pkt_cyc_q.push_back(cyc);
          end
          out_in_pkt = !m_tlast;
          void'(exp_q.pop_front());
        end
      end
    end
    for (int c = 0; c < N_CH; c++) begin
      if (s_tvalid[c] && s_tready[c]) begin
        b = src_q[c].pop_front();
        exp_q.push_back('{1'b0, c, b[DATA_W-1:0], b[DATA_W]});
        open_ch = b[DATA_W] ? -1 : c;
        if (b[DATA_W]) last_hs_ch = c;
      end
    end
    // A channel disabled with a packet open gets a zero-data terminator.
    if (open_ch >= 0 && !ch_en[open_ch]) begin
      exp_q.push_back('{1'b1, open_ch, '0, 1'b1});
      open_ch = -1;
    end
    cyc++;
  endtask

  task automatic tick();
    for (int c = 0; c < N_CH; c++) begin
      if (src_q[c].size() != 0) begin
        s_tvalid[c]                  = 1'b1;
        s_tdata[c*DATA_W +: DATA_W]  = src_q[c][0][DATA_W-1:0];
        s_tlast[c]                   = src_q[c][0][DATA_W];
      end else begin
        s_tvalid[c]                  = 1'b0;
        s_tdata[c*DATA_W +: DATA_W]  = '0;
        s_tlast[c]                   = 1'b0;
      end
    end
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = ($urandom_range(0, 3) != 0);
    endcase
    @(negedge aclk);
    sample();
    @(posedge aclk);
    #1;
  endtask

  function automatic bit all_done();
    if (exp_q.size() != 0) return 1'b0;
    for (int c = 0; c < N_CH; c++)
      if (ch_en[c] && src_q[c].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain();
    int guard = 0;
    while (!all_done() && guard < 3000) begin
      tick();
      guard++;
    end
    check("drain_timeout", 64'(all_done()), 1);
  endtask

  initial begin
    int guard;
    n_cmp = 0; n_err = 0; cyc = 0; rdy_mode = 0;
    open_ch = -1; last_hs_ch = -1; out_in_pkt = 1'b0;
    areset = 1'b1; ch_en = '1; m_tready = 1'b0;
    s_tvalid = '0; s_tdata = '0; s_tlast = '0;
    clear_stats();
    @(posedge aclk);
    #1;

    // Reset with every source valid, then fairness over 2-beat packets.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < N_CH; c++) add_pkt(c, 2);
    tick();
    tick();
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_busy", busy, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_m_tuser", m_tuser, 0);
    areset = 1'b0;
    clear_stats();
    drain();
    check("fair_count", pkt_id_q.size(), 15);
    for (int k = 0; k < pkt_id_q.size(); k++) begin
      check("fair_id", pkt_id_q[k], k % N_CH);
      if (k > 0) check("fair_gap", pkt_cyc_q[k] - pkt_cyc_q[k-1], 3);
    end

    // Back-to-back single-beat packets on B: one beat every two cycles.
    clear_stats();
    for (int i = 0; i < 4; i++) add_pkt(4, 1);
    drain();
    check("single_count", pkt_id_q.size(), 4);
    for (int k = 0; k < pkt_id_q.size(); k++) begin
      check("single_id", pkt_id_q[k], 4);
      if (k > 0) check("single_gap", pkt_cyc_q[k] - pkt_cyc_q[k-1], 2);
    end

    // Backpressure on R with a toggling m_tready.
    clear_stats();
    rdy_mode = 1;
    add_pkt(2, 4);
    drain();
    check("bp_beats", out_beats[2], 4);
    rdy_mode = 0;

    // W disabled after two beats of five; B is waiting behind it.
    clear_stats();
    add_pkt(3, 5);
    guard = 0;
    while (src_q[3].size() > 3 && guard < 100) begin
      tick();
      guard++;
    end
    check("abort_wait", src_q[3].size(), 3);
    add_pkt(4, 1);
    ch_en[3] = 1'b0;
    src_q[3].delete();
    drain();
    check("abort_cnt", abort_cnt, 1);
    check("abort_beats", out_beats[3], 3);
    check("abort_pkts", pkt_id_q.size(), 2);
    if (pkt_id_q.size() == 2) check("abort_next_id", pkt_id_q[1], 4);
    tick();
    check("abort_idle", busy, 0);
    ch_en[3] = 1'b1;

    // Disable immediately after the tlast handshake: no terminator.
    clear_stats();
    last_hs_ch = -1;
    add_pkt(1, 3);
    guard = 0;
    while (last_hs_ch != 1 && guard < 100) begin
      tick();
      guard++;
    end
    check("tlast_wait", last_hs_ch, 1);
    ch_en[1] = 1'b0;
    drain();
    check("tlast_no_abort", abort_cnt, 0);
    check("tlast_beats", out_beats[1], 3);
    ch_en[1] = 1'b1;

    // Disabled AW with pending data stays back-pressured.
    clear_stats();
    ch_en[1] = 1'b0;
    for (int c = 0; c < N_CH; c++) add_pkt(c, 2);
    drain();
    check("dis_no_id1", out_beats[1], 0);
    check("dis_held", src_q[1].size(), 2);
    check("dis_others", out_beats[0] + out_beats[2] + out_beats[3] + out_beats[4], 8);
    ch_en[1] = 1'b1;
    drain();
    check("dis_reenabled", out_beats[1], 2);

    // Reset mid-packet: partial packet is lost and priority restarts at AR.
    add_pkt(2, 4);
    guard = 0;
    while (src_q[2].size() > 2 && guard < 100) begin
      tick();
      guard++;
    end
    check("mid_rst_wait", src_q[2].size(), 2);
    areset = 1'b1;
    #1;
    check("mid_rst_m_tvalid", m_tvalid, 0);
    check("mid_rst_s_tready", s_tready, 0);
    check("mid_rst_busy", busy, 0);
    for (int c = 0; c < N_CH; c++) src_q[c].delete();
    exp_q.delete();
    open_ch = -1;
    out_in_pkt = 1'b0;
    tick();
    areset = 1'b0;
    clear_stats();
    add_pkt(2, 1);
    add_pkt(0, 1);
    drain();
    check("mid_rst_pkts", pkt_id_q.size(), 2);
    if (pkt_id_q.size() == 2) check("mid_rst_first", pkt_id_q[0], 0);

    // Randomized rounds: random enable mask, packet mix and m_tready pattern.
    for (int r = 0; r < 30; r++) begin
      ch_en    = N_CH'($urandom_range(1, 31));
      rdy_mode = $urandom_range(0, 2);
      for (int i = 0; i < int'($urandom_range(3, 10)); i++)
        add_pkt($urandom_range(0, N_CH - 1), $urandom_range(1, 4));
      drain();
      tick();
      check("rand_idle", busy, 0);
      ch_en = '1;
      drain();
    end
    tick();
    check("final_idle", busy, 0);
    check("final_no_abort_open", 64'(open_ch), 64'(-1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
